character_position: RTL and testbench

CHARACTER_POSITION -- requirements
Module: character_position

---
 rtl/character_position.sv | 155 +++++++++++++++
 tb/tb_character_position.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/character_position.sv
// character_position
//   Tracks a sprite position on screen. A free-running divider produces one
//   step cycle every STEP_DIV clocks; in a step cycle the permitted motion
//   (Move_Arrow) moves the position by STEP pixels. The result is clamped to
//   the inclusive bounds and never wraps. A load request respawns the
//   character at a clamped coordinate.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   Move_Arrow   [3] up, [2] down, [1] left, [0] right (permitted motion)
//   load         respawn request
//   load_x/y     respawn coordinates (clamped into bounds)
//   pos_x/y      registered position, y grows downward
//   facing_left  last horizontal direction, 1 = left
//   motion_state 00 GROUND, 01 RISE, 10 FALL
//   step_pulse   one cycle high when a step updated the position
module character_position #(
    parameter int unsigned X_INIT   = 32,
    parameter int unsigned Y_INIT   = 400,
    parameter int unsigned X_MIN    = 0,
    parameter int unsigned X_MAX    = 624,
    parameter int unsigned Y_MIN    = 0,
    parameter int unsigned Y_MAX    = 448,
    parameter int unsigned STEP     = 2,
    parameter int unsigned STEP_DIV = 250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Move_Arrow,
    input  logic       load,
    input  logic [9:0] load_x,
    input  logic [9:0] load_y,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic       facing_left,
    output logic [1:0] motion_state,
    output logic       step_pulse
);

    localparam int unsigned DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

    localparam logic [9:0]  X_MIN_P = 10'(X_MIN);
    localparam logic [9:0]  X_MAX_P = 10'(X_MAX);
    localparam logic [9:0]  Y_MIN_P = 10'(Y_MIN);
    localparam logic [9:0]  Y_MAX_P = 10'(Y_MAX);
    localparam logic [9:0]  STEP_P  = 10'(STEP);
    localparam logic [10:0] X_MIN_W = 11'(X_MIN);
    localparam logic [10:0] X_MAX_W = 11'(X_MAX);
    localparam logic [10:0] Y_MIN_W = 11'(Y_MIN);
    localparam logic [10:0] Y_MAX_W = 11'(Y_MAX);
    localparam logic [10:0] STEP_W  = 11'(STEP);

    typedef enum logic [1:0] {
        GROUND = 2'b00,
        RISE   = 2'b01,
        FALL   = 2'b10
    } motion_t;

    motion_t           state;
    motion_t           state_next;
    logic [DIV_W-1:0]  div_cnt;
    logic              step;
    logic              up_only;
    logic              down_only;
    logic              left_only;
    logic              right_only;
    logic [10:0]       x_sum;
    logic [10:0]       y_sum;
    logic [9:0]        x_next;
    logic [9:0]        y_next;
    logic [9:0]        load_x_clamped;
    logic [9:0]        load_y_clamped;

    assign step       = (div_cnt == DIV_LAST);
    assign up_only    = Move_Arrow[3] & ~Move_Arrow[2];
    assign down_only  = Move_Arrow[2] & ~Move_Arrow[3];
    assign left_only  = Move_Arrow[1] & ~Move_Arrow[0];
    assign right_only = Move_Arrow[0] & ~Move_Arrow[1];

    // Increments use an 11-bit sum so the upper-bound test cannot overflow;
    // decrements test against MIN+STEP first so the subtraction never
    // underflows.
    always_comb begin
        x_sum  = {1'b0, pos_x} + STEP_W;
        y_sum  = {1'b0, pos_y} + STEP_W;
        x_next = pos_x;
        y_next = pos_y;
        if (right_only) begin
            x_next = (x_sum > X_MAX_W) ? X_MAX_P : x_sum[9:0];
        end else if (left_only) begin
            x_next = ({1'b0, pos_x} < X_MIN_W + STEP_W) ? X_MIN_P : pos_x - STEP_P;
        end
        if (down_only) begin
            y_next = (y_sum > Y_MAX_W) ? Y_MAX_P : y_sum[9:0];
        end else if (up_only) begin
            y_next = ({1'b0, pos_y} < Y_MIN_W + STEP_W) ? Y_MIN_P : pos_y - STEP_P;
        end
    end

    always_comb begin
        load_x_clamped = load_x;
        load_y_clamped = load_y;
        if (load_x > X_MAX_P)      load_x_clamped = X_MAX_P;
        else if (load_x < X_MIN_P) load_x_clamped = X_MIN_P;
        if (load_y > Y_MAX_P)      load_y_clamped = Y_MAX_P;
        else if (load_y < Y_MIN_P) load_y_clamped = Y_MIN_P;
    end

    // Divider, position, facing and step pulse. Load wins over a coinciding
    // step and restarts the divider.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt     <= '0;
            pos_x       <= 10'(X_INIT);
            pos_y       <= 10'(Y_INIT);
            facing_left <= 1'b0;
            step_pulse  <= 1'b0;
        end else if (load) begin
            div_cnt     <= '0;
            pos_x       <= load_x_clamped;
            pos_y       <= load_y_clamped;
            step_pulse  <= 1'b0;
        end else begin
            div_cnt    <= step ? '0 : div_cnt + DIV_W'(1);
            step_pulse <= step;
            if (step) begin
                pos_x <= x_next;
                pos_y <= y_next;
                if (left_only)       facing_left <= 1'b1;
                else if (right_only) facing_left <= 1'b0;
            end
        end
    end

    // Motion FSM: state register
    always_ff @(posedge clk) begin
        if (rst || load) state <= GROUND;
        else if (step)   state <= state_next;
    end

    // Motion FSM: next state depends only on the sampled vertical request
    always_comb begin
        state_next = GROUND;
        if (up_only)        state_next = RISE;
        else if (down_only) state_next = FALL;
    end

    // Motion FSM: output
    always_comb begin
        motion_state = state;
    end

endmodule

// File: tb/tb_character_position.sv
module tb_character_position;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] Move_Arrow = '0;
    logic       load = 1'b0;
    logic [9:0] load_x = '0;
    logic [9:0] load_y = '0;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic       facing_left;
    logic [1:0] motion_state;
    logic       step_pulse;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    character_position #(
        .STEP_DIV(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .Move_Arrow(Move_Arrow),
        .load(load),
        .load_x(load_x),
        .load_y(load_y),
        .pos_x(pos_x),
        .pos_y(pos_y),
        .facing_left(facing_left),
        .motion_state(motion_state),
        .step_pulse(step_pulse)
    );

    typedef struct {
        logic       rst;
        logic       load;
        logic [3:0] mv;
        logic [9:0] lx;
        logic [9:0] ly;
        logic [9:0] ex;
        logic [9:0] ey;
        logic       ef;
        logic [1:0] ems;
        logic       esp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic ld, input logic [3:0] mv,
                       input logic [9:0] lx, input logic [9:0] ly,
                       input logic [9:0] ex, input logic [9:0] ey,
                       input logic ef, input logic [1:0] ems, input logic esp);
        vec_t v;
        v.rst = r; v.load = ld; v.mv = mv; v.lx = lx; v.ly = ly;
        v.ex = ex; v.ey = ey; v.ef = ef; v.ems = ems; v.esp = esp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int unsigned idx,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    // Apply inputs just after an edge, let the next edge capture them, and
    // sample 1 time unit later.
    task automatic cycle(input logic r, input logic ld, input logic [3:0] mv,
                         input logic [9:0] lx, input logic [9:0] ly);
        rst = r; load = ld; Move_Arrow = mv; load_x = lx; load_y = ly;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned hits;
        int unsigned wait_cnt;
        logic found;

        // Reset
        add(1, 0, 4'b0000, 0, 0,   32, 400, 0, 2'b00, 0);
        // Right for 8 cycles: steps on the 4th and 8th edges
        add(0, 0, 4'b0001, 0, 0,   32, 400, 0, 2'b00, 0);
        add(0, 0, 4'b0001, 0, 0,   32, 400, 0, 2'b00, 0);
        add(0, 0, 4'b0001, 0, 0,   32, 400, 0, 2'b00, 0);
        add(0, 0, 4'b0001, 0, 0,   34, 400, 0, 2'b00, 1);
        add(0, 0, 4'b0001, 0, 0,   34, 400, 0, 2'b00, 0);
        add(0, 0, 4'b0001, 0, 0,   34, 400, 0, 2'b00, 0);
        add(0, 0, 4'b0001, 0, 0,   34, 400, 0, 2'b00, 0);
        add(0, 0, 4'b0001, 0, 0,   36, 400, 0, 2'b00, 1);
        // Respawn at x=1, then left: clamps at 0
        add(0, 1, 4'b0010, 1, 400, 1,  400, 0, 2'b00, 0);
        add(0, 0, 4'b0010, 0, 0,   1,  400, 0, 2'b00, 0);
        add(0, 0, 4'b0010, 0, 0,   1,  400, 0, 2'b00, 0);
        add(0, 0, 4'b0010, 0, 0,   1,  400, 0, 2'b00, 0);
        add(0, 0, 4'b0010, 0, 0,   0,  400, 1, 2'b00, 1);
        add(0, 0, 4'b0010, 0, 0,   0,  400, 1, 2'b00, 0);
        add(0, 0, 4'b0010, 0, 0,   0,  400, 1, 2'b00, 0);
        add(0, 0, 4'b0010, 0, 0,   0,  400, 1, 2'b00, 0);
        add(0, 0, 4'b0010, 0, 0,   0,  400, 1, 2'b00, 1);
        // Up -> RISE
        add(0, 0, 4'b1000, 0, 0,   0,  400, 1, 2'b00, 0);
        add(0, 0, 4'b1000, 0, 0,   0,  400, 1, 2'b00, 0);
        add(0, 0, 4'b1000, 0, 0,   0,  400, 1, 2'b00, 0);
        add(0, 0, 4'b1000, 0, 0,   0,  398, 1, 2'b01, 1);
        // Down -> FALL
        add(0, 0, 4'b0100, 0, 0,   0,  398, 1, 2'b01, 0);
        add(0, 0, 4'b0100, 0, 0,   0,  398, 1, 2'b01, 0);
        add(0, 0, 4'b0100, 0, 0,   0,  398, 1, 2'b01, 0);
        add(0, 0, 4'b0100, 0, 0,   0,  400, 1, 2'b10, 1);
        // Up+down -> GROUND, no vertical motion
        add(0, 0, 4'b1100, 0, 0,   0,  400, 1, 2'b10, 0);
        add(0, 0, 4'b1100, 0, 0,   0,  400, 1, 2'b10, 0);
        add(0, 0, 4'b1100, 0, 0,   0,  400, 1, 2'b10, 0);
        add(0, 0, 4'b1100, 0, 0,   0,  400, 1, 2'b00, 1);
        // Load out of range on the step cycle: clamped, step discarded
        add(0, 0, 4'b0001, 0, 0,   0,  400, 1, 2'b00, 0);
        add(0, 0, 4'b0001, 0, 0,   0,  400, 1, 2'b00, 0);
        add(0, 0, 4'b0001, 0, 0,   0,  400, 1, 2'b00, 0);
        add(0, 1, 4'b0001, 700, 500, 624, 448, 1, 2'b00, 0);
        add(0, 0, 4'b0001, 0, 0,   624, 448, 1, 2'b00, 0);
        add(0, 0, 4'b0001, 0, 0,   624, 448, 1, 2'b00, 0);
        add(0, 0, 4'b0001, 0, 0,   624, 448, 1, 2'b00, 0);
        add(0, 0, 4'b0001, 0, 0,   624, 448, 0, 2'b00, 1);
        // Up near the top clamps at 0
        add(0, 1, 4'b1000, 5, 1,   5,  1,   0, 2'b00, 0);
        add(0, 0, 4'b1000, 0, 0,   5,  1,   0, 2'b00, 0);
        add(0, 0, 4'b1000, 0, 0,   5,  1,   0, 2'b00, 0);
        add(0, 0, 4'b1000, 0, 0,   5,  1,   0, 2'b00, 0);
        add(0, 0, 4'b1000, 0, 0,   5,  0,   0, 2'b01, 1);
        // Down at the bottom edge clamps at 448
        add(0, 1, 4'b0100, 9, 447, 9,  447, 0, 2'b00, 0);
        add(0, 0, 4'b0100, 0, 0,   9,  447, 0, 2'b00, 0);
        add(0, 0, 4'b0100, 0, 0,   9,  447, 0, 2'b00, 0);
        add(0, 0, 4'b0100, 0, 0,   9,  447, 0, 2'b00, 0);
        add(0, 0, 4'b0100, 0, 0,   9,  448, 0, 2'b10, 1);

        @(posedge clk);
        #1;
        for (int unsigned i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].rst, vecs[i].load, vecs[i].mv, vecs[i].lx, vecs[i].ly);
            check("pos_x",        i, 32'(pos_x),        32'(vecs[i].ex));
            check("pos_y",        i, 32'(pos_y),        32'(vecs[i].ey));
            check("facing_left",  i, 32'(facing_left),  32'(vecs[i].ef));
            check("motion_state", i, 32'(motion_state), 32'(vecs[i].ems));
            check("step_pulse",   i, 32'(step_pulse),   32'(vecs[i].esp));
        end

        // Reset, then walk right until x reaches 40 (four steps)
        cycle(1, 0, 4'b0000, 0, 0);
        found = 1'b0;
        for (int unsigned i = 0; i < 40 && !found; i++) begin
            cycle(0, 0, 4'b0001, 0, 0);
            if (pos_x == 10'd40) found = 1'b1;
        end
        check("reach_x40", 0, 32'(found), 32'd1);

        // Divider is 0 now; three more edges put it in the step cycle,
        // where reset must discard the pending move.
        cycle(0, 0, 4'b0001, 0, 0);
        cycle(0, 0, 4'b0001, 0, 0);
        cycle(0, 0, 4'b0001, 0, 0);
        check("pre_rst_x", 0, 32'(pos_x), 32'd40);
        cycle(1, 0, 4'b0001, 0, 0);
        check("rst_x",     0, 32'(pos_x),        32'd32);
        check("rst_ms",    0, 32'(motion_state), 32'd0);
        check("rst_sp",    0, 32'(step_pulse),   32'd0);
        check("rst_face",  0, 32'(facing_left),  32'd0);

        // First step exactly STEP_DIV edges after reset releases
        wait_cnt = 0;
        hits = 0;
        for (int unsigned i = 0; i < 10 && hits == 0; i++) begin
            cycle(0, 0, 4'b0001, 0, 0);
            wait_cnt++;
            if (step_pulse) hits++;
        end
        check("first_step_delay", 0, 32'(wait_cnt), 32'd4);
        check("first_step_x",     0, 32'(pos_x),    32'd34);

        // Load mid-period restarts the divider: next step 4 edges later
        cycle(0, 0, 4'b0001, 0, 0);
        cycle(0, 1, 4'b0001, 100, 200);
        check("mid_load_x", 0, 32'(pos_x), 32'd100);
        check("mid_load_y", 0, 32'(pos_y), 32'd200);
        hits = 0;
        for (int unsigned i = 0; i < 4; i++) begin
            cycle(0, 0, 4'b0001, 0, 0);
            if (step_pulse) hits++;
        end
        check("mid_load_pulses", 0, 32'(hits), 32'd1);
        check("mid_load_last",   0, 32'(step_pulse), 32'd1);
        check("mid_load_x2",     0, 32'(pos_x), 32'd102);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
